// File: rtl/byte_seq_ctrl_if.sv
// Handshake bundle between a word producer, the byte sequencer and a byte consumer.
// out_last exists only when BYTE_SEQ_LAST_EN is defined.
interface byte_seq_ctrl_if;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready;
  logic        busy;
`ifdef BYTE_SEQ_LAST_EN
  logic        out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy, out_last
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, busy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, busy
  );
`endif
endinterface

// File: rtl/byte_seq_ctrl.sv
// Latches one 32-bit word and emits its four bytes, one per accepted output beat.
// Define BYTE_SEQ_LAST_EN to add out_last, flagging the final byte of each word.
module byte_seq_ctrl #(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  byte_seq_ctrl_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_next;
  logic [31:0] word, word_next;
  logic [1:0]  idx, idx_next;
  logic [1:0]  sel;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      word  <= '0;
      idx   <= '0;
    end else begin
      state <= state_next;
      word  <= word_next;
      idx   <= idx_next;
    end
  end

  // The last beat can reload the next word directly, so words stream without a gap.
  always_comb begin
    state_next    = state;
    word_next     = word;
    idx_next      = idx;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        if (bus.in_valid) begin
          word_next  = bus.in_data;
          idx_next   = 2'd0;
          state_next = SEND;
        end
      end
      SEND: begin
        bus.out_valid = 1'b1;
        bus.busy      = 1'b1;
        bus.in_ready  = (idx == 2'd3) && bus.out_ready;
        if (bus.out_ready) begin
          if (idx != 2'd3) begin
            idx_next = idx + 2'd1;
          end else if (bus.in_valid) begin
            word_next = bus.in_data;
            idx_next  = 2'd0;
          end else begin
            idx_next   = 2'd0;
            state_next = IDLE;
          end
        end
      end
    endcase
  end

  assign sel          = MSB_FIRST ? (2'd3 - idx) : idx;
  assign bus.out_data = (state == SEND) ? word[{sel, 3'b000} +: 8] : 8'h00;

`ifdef BYTE_SEQ_LAST_EN
  assign bus.out_last = (state == SEND) && (idx == 2'd3);
`endif

endmodule

// File: tb/tb_byte_seq_ctrl.sv
// Bench for byte_seq_ctrl: directed vector table, hand-written stall sequence, random traffic vs queue model.
// Both byte orders are instantiated side by side and share one stimulus.
module tb_byte_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [31:0] in_data;
  logic        out_ready;

  int errors = 0;
  int checks = 0;
  bit model_on = 1'b0;

  always #5 clk = ~clk;

  byte_seq_ctrl_if bus_fwd ();
  byte_seq_ctrl_if bus_rev ();

  assign bus_fwd.in_valid  = in_valid;
  assign bus_fwd.in_data   = in_data;
  assign bus_fwd.out_ready = out_ready;
  assign bus_rev.in_valid  = in_valid;
  assign bus_rev.in_data   = in_data;
  assign bus_rev.out_ready = out_ready;

  byte_seq_ctrl #(.MSB_FIRST(1)) dut     (.clk(clk), .reset(reset), .bus(bus_fwd.slave));
  byte_seq_ctrl #(.MSB_FIRST(0)) dut_rev (.clk(clk), .reset(reset), .bus(bus_rev.slave));

  typedef struct {
    logic        rst;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        ev;
    logic [7:0]  ed;
    logic [7:0]  er;
    logic        erdy;
    logic        ebusy;
    logic        elast;
  } vec_t;

  vec_t vecs[$];

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reference model: the bytes still owed to the consumer, in emission order.
  logic [7:0] q_fwd[$];
  logic [7:0] q_rev[$];
  bit model_acc;

  function automatic bit model_in_ready();
    return (q_fwd.size() == 0) || (q_fwd.size() == 1 && out_ready);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      q_fwd.delete();
      q_rev.delete();
    end else begin
      model_acc = in_valid && model_in_ready();
      if (q_fwd.size() != 0 && out_ready) begin
        void'(q_fwd.pop_front());
        void'(q_rev.pop_front());
      end
      if (model_acc) begin
        for (int k = 0; k < 4; k++) begin
          q_fwd.push_back(in_data[31 - 8*k -: 8]);
          q_rev.push_back(in_data[8*k +: 8]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      check_output("mdl_fwd_valid", bus_fwd.out_valid, q_fwd.size() != 0);
      check_output("mdl_fwd_data",  bus_fwd.out_data,  (q_fwd.size() != 0) ? q_fwd[0] : 8'h00);
      check_output("mdl_fwd_busy",  bus_fwd.busy,      q_fwd.size() != 0);
      check_output("mdl_fwd_ready", bus_fwd.in_ready,  model_in_ready());
      check_output("mdl_rev_valid", bus_rev.out_valid, q_rev.size() != 0);
      check_output("mdl_rev_data",  bus_rev.out_data,  (q_rev.size() != 0) ? q_rev[0] : 8'h00);
      check_output("mdl_rev_busy",  bus_rev.busy,      q_rev.size() != 0);
      check_output("mdl_rev_ready", bus_rev.in_ready,  model_in_ready());
`ifdef BYTE_SEQ_LAST_EN
      check_output("mdl_fwd_last",  bus_fwd.out_last,  q_fwd.size() == 1);
      check_output("mdl_rev_last",  bus_rev.out_last,  q_rev.size() == 1);
`endif
    end
  end

  task automatic apply_stimulus(input vec_t v, input int row);
    reset     = v.rst;
    in_valid  = v.iv;
    in_data   = v.id;
    out_ready = v.ordy;
    @(negedge clk);
    check_output($sformatf("row%0d_valid", row), bus_fwd.out_valid, v.ev);
    check_output($sformatf("row%0d_data", row),  bus_fwd.out_data,  v.ed);
    check_output($sformatf("row%0d_rev", row),   bus_rev.out_data,  v.er);
    check_output($sformatf("row%0d_ready", row), bus_fwd.in_ready,  v.erdy);
    check_output($sformatf("row%0d_busy", row),  bus_fwd.busy,      v.ebusy);
`ifdef BYTE_SEQ_LAST_EN
    check_output($sformatf("row%0d_last", row),  bus_fwd.out_last,  v.elast);
`endif
    next_cycle();
  endtask

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = 32'h0;
    out_ready = 1'b0;
    next_cycle();
    model_on = 1'b1;
    next_cycle();

    //               rst iv  id            ordy ev  ed     er     rdy busy last
    vecs.push_back('{0, 1, 32'h12345678, 1, 0, 8'h00, 8'h00, 1, 0, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h12, 8'h78, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h34, 8'h56, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h56, 8'h34, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h78, 8'h12, 1, 1, 1});
    vecs.push_back('{0, 1, 32'hDEADBEEF, 1, 0, 8'h00, 8'h00, 1, 0, 0});
    vecs.push_back('{0, 0, 32'h00000000, 0, 1, 8'hDE, 8'hEF, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 0, 1, 8'hDE, 8'hEF, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 0, 1, 8'hDE, 8'hEF, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'hDE, 8'hEF, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'hAD, 8'hBE, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'hBE, 8'hAD, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'hEF, 8'hDE, 1, 1, 1});
    vecs.push_back('{0, 1, 32'hAABBCCDD, 1, 0, 8'h00, 8'h00, 1, 0, 0});
    vecs.push_back('{0, 1, 32'h01020304, 1, 1, 8'hAA, 8'hDD, 0, 1, 0});
    vecs.push_back('{0, 1, 32'h01020304, 1, 1, 8'hBB, 8'hCC, 0, 1, 0});
    vecs.push_back('{0, 1, 32'h01020304, 1, 1, 8'hCC, 8'hBB, 0, 1, 0});
    vecs.push_back('{0, 1, 32'h01020304, 1, 1, 8'hDD, 8'hAA, 1, 1, 1});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h01, 8'h04, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h02, 8'h03, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h03, 8'h02, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h04, 8'h01, 1, 1, 1});
    vecs.push_back('{0, 1, 32'hAABBCCDD, 1, 0, 8'h00, 8'h00, 1, 0, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'hAA, 8'hDD, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'hBB, 8'hCC, 0, 1, 0});
    vecs.push_back('{1, 0, 32'h00000000, 1, 1, 8'hCC, 8'hBB, 0, 1, 0});
    vecs.push_back('{0, 1, 32'h11223344, 1, 0, 8'h00, 8'h00, 1, 0, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h11, 8'h44, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h22, 8'h33, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h33, 8'h22, 0, 1, 0});
    vecs.push_back('{0, 0, 32'h00000000, 1, 1, 8'h44, 8'h11, 1, 1, 1});
    vecs.push_back('{0, 0, 32'h00000000, 1, 0, 8'h00, 8'h00, 1, 0, 0});

    for (int i = 0; i < vecs.size(); i++) begin
      apply_stimulus(vecs[i], i);
    end

    // Stall on the final byte with the next word waiting: must hold and refuse input.
    reset     = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hCAFEF00D;
    out_ready = 1'b1;
    @(negedge clk);
    check_output("cafe_accept_ready", bus_fwd.in_ready, 1'b1);
    next_cycle();
    in_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output($sformatf("cafe_byte%0d", k), bus_fwd.out_data, 32'hCAFEF00D >> (24 - 8*k) & 32'hFF);
`ifdef BYTE_SEQ_LAST_EN
      check_output($sformatf("cafe_last%0d", k), bus_fwd.out_last, 1'b0);
`endif
      next_cycle();
    end
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h5A6B7C8D;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_output("cafe_stall_data",  bus_fwd.out_data,  8'h0D);
      check_output("cafe_stall_valid", bus_fwd.out_valid, 1'b1);
      check_output("cafe_stall_ready", bus_fwd.in_ready,  1'b0);
`ifdef BYTE_SEQ_LAST_EN
      check_output("cafe_stall_last",  bus_fwd.out_last,  1'b1);
`endif
      next_cycle();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check_output("cafe_release_ready", bus_fwd.in_ready, 1'b1);
    check_output("cafe_release_data",  bus_fwd.out_data, 8'h0D);
    next_cycle();
    in_valid = 1'b0;
    @(negedge clk);
    check_output("cafe_next_word", bus_fwd.out_data, 8'h5A);
    check_output("cafe_next_rev",  bus_rev.out_data, 8'h8D);
    repeat (4) next_cycle();

    // Random traffic with occasional resets, checked only by the model.
    for (int i = 0; i < 3000; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      next_cycle();
    end

    model_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
